// File: rtl/port_pkt_tx.sv
// ---------------------------------------------------------------------------
// port_pkt_tx
//
// Per-port packet transmitter. Host requests are queued in a small FIFO.
// Each one is classified with the same legality rules the switch parser
// uses. Illegal requests are dropped and counted. Legal ones are presented
// to the switch as {source, target, type, data} over a valid/ready
// handshake. Packets leave in the order they were accepted.
//
// Optional feature (compile-time macro): TX_TIMEOUT_EN
//   When defined, a packet that stalls for TIMEOUT cycles is abandoned.
//   tx_timeout_o pulses for one cycle and the FSM returns to IDLE.
//   When undefined, SEND waits indefinitely and tx_timeout_o is tied to 0.
//
// Packet type encoding (tx_type_o):
//   2'd0 ERR (idle / no packet)
//   2'd1 SDP (single destination)
//   2'd2 MDP (2 or 3 destinations)
//   2'd3 BDP (broadcast)
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   req_valid_i  host request valid
//   req_ready_o  FIFO not full (from the registered count)
//   req_target_i destination port mask of the request
//   req_data_i   request payload
//   tx_valid_o   packet valid toward the switch
//   tx_ready_i   switch accepts the packet
//   tx_source_o  one-hot source, 4'b0001 << PORT_ID (constant)
//   tx_target_o  destination mask of the current packet
//   tx_data_o    payload of the current packet
//   tx_type_o    packet type; ERR when idle
//   drop_cnt_o   saturating count of illegal requests
//   tx_timeout_o one-cycle abort pulse
//   busy_o       FIFO non-empty or packet in flight
// ---------------------------------------------------------------------------
module port_pkt_tx #(
    parameter int PORT_ID = 0,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_target_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [3:0]        tx_source_o,
    output logic [3:0]        tx_target_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic [1:0]        tx_type_o,
    output logic [7:0]        drop_cnt_o,
    output logic              tx_timeout_o,
    output logic              busy_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [3:0] SOURCE = 4'(4'b0001 << PORT_ID);

    localparam logic [1:0] TYPE_ERR = 2'd0;
    localparam logic [1:0] TYPE_SDP = 2'd1;
    localparam logic [1:0] TYPE_MDP = 2'd2;
    localparam logic [1:0] TYPE_BDP = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO: entry = {target, data}
    // ------------------------------------------------------------------
    logic [DATA_W+3:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push;
    logic              pop;
    logic              fifo_nempty;

    // Full is judged on the registered count only, so a same-cycle pop
    // never lets a push through a full FIFO.
    assign req_ready_o = (count_q != CW'(DEPTH));
    assign fifo_nempty = (count_q != '0);
    assign push        = req_valid_i && req_ready_o;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req_target_i, req_data_i};
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Classification of the FIFO head
    // ------------------------------------------------------------------
    logic [3:0]        head_target;
    logic [DATA_W-1:0] head_data;
    logic [2:0]        head_pop;
    logic [1:0]        head_type;
    logic              head_legal;

    assign head_target = mem_q[rd_ptr_q][DATA_W+3:DATA_W];
    assign head_data   = mem_q[rd_ptr_q][DATA_W-1:0];
    assign head_pop    = {2'b00, head_target[0]} + {2'b00, head_target[1]}
                       + {2'b00, head_target[2]} + {2'b00, head_target[3]};

    always_comb begin
        case (head_pop)
            3'd1:       head_type = TYPE_SDP;
            3'd2, 3'd3: head_type = TYPE_MDP;
            3'd4:       head_type = TYPE_BDP;
            default:    head_type = TYPE_ERR;
        endcase
    end

    // Targeting our own port is illegal except as part of a broadcast.
    assign head_legal = (head_target != 4'h0)
                     && (((head_target & SOURCE) == 4'h0) || (head_target == 4'hF));

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [3:0]        tx_target_q, tx_target_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [1:0]        tx_type_q, tx_type_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              drop_inc;
`ifdef TX_TIMEOUT_EN
    logic [7:0]        stall_q, stall_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        tx_target_d = tx_target_q;
        tx_data_d   = tx_data_q;
        tx_type_d   = tx_type_q;
        pop         = 1'b0;
        drop_inc    = 1'b0;
`ifdef TX_TIMEOUT_EN
        stall_d     = stall_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (fifo_nempty) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        tx_target_d = head_target;
                        tx_data_d   = head_data;
                        tx_type_d   = head_type;
                        state_d     = SEND;
`ifdef TX_TIMEOUT_EN
                        stall_d     = '0;
`endif
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            SEND: begin
                if (tx_ready_i) begin
`ifdef TX_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (fifo_nempty) begin
                        pop = 1'b1;
                        if (head_legal) begin
                            // Back-to-back: next packet loads on the handshake edge.
                            tx_target_d = head_target;
                            tx_data_d   = head_data;
                            tx_type_d   = head_type;
                        end else begin
                            drop_inc  = 1'b1;
                            tx_type_d = TYPE_ERR;
                            state_d   = IDLE;
                        end
                    end else begin
                        tx_type_d = TYPE_ERR;
                        state_d   = IDLE;
                    end
                end
`ifdef TX_TIMEOUT_EN
                // This cycle is the TIMEOUT-th consecutive stall: abandon.
                else if (stall_q == 8'(TIMEOUT - 1)) begin
                    tx_type_d = TYPE_ERR;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stall_d = stall_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign drop_cnt_d = (drop_inc && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1
                                                            : drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tx_target_q <= '0;
            tx_data_q   <= '0;
            tx_type_q   <= TYPE_ERR;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tx_target_q <= tx_target_d;
            tx_data_q   <= tx_data_d;
            tx_type_q   <= tx_type_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

`ifdef TX_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end
    assign tx_timeout_o = timeout_q;
`else
    assign tx_timeout_o = 1'b0;
`endif

    assign tx_valid_o  = (state_q == SEND);
    assign tx_source_o = SOURCE;
    assign tx_target_o = tx_target_q;
    assign tx_data_o   = tx_data_q;
    assign tx_type_o   = tx_type_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign busy_o      = fifo_nempty || tx_valid_o;

endmodule

// File: tb/tb_port_pkt_tx.sv
// ---------------------------------------------------------------------------
// tb_port_pkt_tx
//
// Directed bench for port_pkt_tx. Two instances share the host-side
// stimulus: u_dut0 (PORT_ID=0) and u_dut1 (PORT_ID=1). Each scenario task
// checks the instance that its stimulus targets. Inputs change and outputs
// are sampled 1 ns after the rising edge.
// Type codes: ERR=0, SDP=1, MDP=2, BDP=3.
// ---------------------------------------------------------------------------
module tb_port_pkt_tx;

    localparam logic [1:0] T_ERR = 2'd0;
    localparam logic [1:0] T_SDP = 2'd1;
    localparam logic [1:0] T_MDP = 2'd2;
    localparam logic [1:0] T_BDP = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_target = 4'h0;
    logic [7:0] req_data = 8'h00;
    logic       tx_ready = 1'b0;

    logic       req_ready0, tx_valid0, tx_timeout0, busy0;
    logic [3:0] tx_source0, tx_target0;
    logic [7:0] tx_data0, drop_cnt0;
    logic [1:0] tx_type0;

    logic       req_ready1, tx_valid1, tx_timeout1, busy1;
    logic [3:0] tx_source1, tx_target1;
    logic [7:0] tx_data1, drop_cnt1;
    logic [1:0] tx_type1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    port_pkt_tx #(.PORT_ID(0), .DATA_W(8), .DEPTH(4), .TIMEOUT(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready0),
        .req_target_i(req_target), .req_data_i(req_data),
        .tx_valid_o(tx_valid0), .tx_ready_i(tx_ready),
        .tx_source_o(tx_source0), .tx_target_o(tx_target0),
        .tx_data_o(tx_data0), .tx_type_o(tx_type0),
        .drop_cnt_o(drop_cnt0), .tx_timeout_o(tx_timeout0), .busy_o(busy0)
    );

    port_pkt_tx #(.PORT_ID(1), .DATA_W(8), .DEPTH(4), .TIMEOUT(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready1),
        .req_target_i(req_target), .req_data_i(req_data),
        .tx_valid_o(tx_valid1), .tx_ready_i(tx_ready),
        .tx_source_o(tx_source1), .tx_target_o(tx_target1),
        .tx_data_o(tx_data1), .tx_type_o(tx_type1),
        .drop_cnt_o(drop_cnt1), .tx_timeout_o(tx_timeout1), .busy_o(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        tx_ready  = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Holds a request until u_dut1 accepts it (bounded).
    task automatic push(input logic [3:0] t, input logic [7:0] d);
        logic acc;
        acc = 1'b0;
        req_valid  = 1'b1;
        req_target = t;
        req_data   = d;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = req_ready1;
            tick();
        end
        req_valid = 1'b0;
        tests_run++;
        if (acc !== 1'b1) begin
            tests_failed++;
            $display("FAIL push_accept: target=%b data=%h accepted=%b required=1", t, d, acc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({tx_valid1, tx_target1, tx_data1, tx_type1} !== {1'b0, 4'h0, 8'h00, T_ERR}) begin
            tests_failed++;
            $display("FAIL reset_tx: valid=%b target=%h data=%h type=%0d required 0/0/00/0",
                     tx_valid1, tx_target1, tx_data1, tx_type1);
        end
        tests_run++;
        if ({drop_cnt1, tx_timeout1, busy1, req_ready1} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_misc: drop=%0d timeout=%b busy=%b ready=%b required 0/0/0/1",
                     drop_cnt1, tx_timeout1, busy1, req_ready1);
        end
        tests_run++;
        if ({tx_source0, tx_source1} !== {4'b0001, 4'b0010}) begin
            tests_failed++;
            $display("FAIL reset_source: src0=%b src1=%b required 0001/0010", tx_source0, tx_source1);
        end
    endtask

    // PORT_ID=0, one SDP packet, ready always high.
    task automatic test_single();
        do_reset();
        tx_ready = 1'b1;
        push(4'b0100, 8'hA5);          // accepted at E0
        tests_run++;
        if (tx_valid0 !== 1'b0 || busy0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_e0: valid=%b busy=%b required 0/1", tx_valid0, busy0);
        end
        tick();                        // E1
        $display("[TB] pkt src=%b tgt=%b type=%0d data=%h valid=%b",
                 tx_source0, tx_target0, tx_type0, tx_data0, tx_valid0);
        tests_run++;
        if ({tx_valid0, tx_source0, tx_target0, tx_type0, tx_data0} !==
            {1'b1, 4'b0001, 4'b0100, T_SDP, 8'hA5}) begin
            tests_failed++;
            $display("FAIL single_pkt: valid=%b src=%b tgt=%b type=%0d data=%h required 1/0001/0100/1/a5",
                     tx_valid0, tx_source0, tx_target0, tx_type0, tx_data0);
        end
        tick();                        // E2: handshake, FIFO empty
        tests_run++;
        if ({tx_valid0, tx_type0, busy0} !== {1'b0, T_ERR, 1'b0}) begin
            tests_failed++;
            $display("FAIL single_idle: valid=%b type=%0d busy=%b required 0/0/0",
                     tx_valid0, tx_type0, busy0);
        end
    endtask

    // PORT_ID=1: 0010 (own port) and 0000 dropped, 1111 BDP, 0101 MDP.
    task automatic test_classify();
        logic [3:0] tg [4];
        logic [1:0] ty [4];
        logic [7:0] dt [4];
        int n;
        do_reset();
        push(4'b0010, 8'h11);
        push(4'b0000, 8'h22);
        push(4'b1111, 8'h33);
        push(4'b0101, 8'h44);
        tick();
        tick();
        tx_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid1 === 1'b1 && n < 4) begin
                $display("[TB] pkt src=%b tgt=%b type=%0d data=%h",
                         tx_source1, tx_target1, tx_type1, tx_data1);
                tg[n] = tx_target1;
                ty[n] = tx_type1;
                dt[n] = tx_data1;
                n++;
            end
            tick();
        end
        tests_run++;
        if (n != 2) begin
            tests_failed++;
            $display("FAIL classify_count: packets=%0d required 2", n);
        end else begin
            tests_run++;
            if ({tg[0], ty[0], dt[0]} !== {4'b1111, T_BDP, 8'h33}) begin
                tests_failed++;
                $display("FAIL classify_pkt0: tgt=%b type=%0d data=%h required 1111/3/33",
                         tg[0], ty[0], dt[0]);
            end
            tests_run++;
            if ({tg[1], ty[1], dt[1]} !== {4'b0101, T_MDP, 8'h44}) begin
                tests_failed++;
                $display("FAIL classify_pkt1: tgt=%b type=%0d data=%h required 0101/2/44",
                         tg[1], ty[1], dt[1]);
            end
        end
        tests_run++;
        if (drop_cnt1 !== 8'd2) begin
            tests_failed++;
            $display("FAIL classify_drop: drop_cnt=%0d required 2", drop_cnt1);
        end
    endtask

    // Stall with FIFO full, then release: five packets with no bubble.
    task automatic test_back_to_back();
        int acc, run, first, gaps;
        logic ready_s;
        logic [7:0] exp_d;
        do_reset();
        acc = 0;
        req_valid  = 1'b1;
        req_target = 4'b0001;
        req_data   = 8'h50;
        for (int i = 0; i < 10; i++) begin
            ready_s = req_ready1;
            tick();
            if (ready_s) begin
                acc++;
                req_data = 8'h50 + 8'(acc);
            end
        end
        req_valid = 1'b0;
        tests_run++;
        if (acc != 5 || req_ready1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept: accepted=%0d ready=%b required 5/0", acc, req_ready1);
        end
        tx_ready = 1'b1;
        run = 0; first = -1; gaps = 0; exp_d = 8'h50;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid1 === 1'b1) begin
                $display("[TB] pkt tgt=%b type=%0d data=%h", tx_target1, tx_type1, tx_data1);
                if (first < 0) first = i;
                if (i != first + run) gaps++;
                if (tx_data1 !== exp_d) gaps++;
                exp_d = exp_d + 8'd1;
                run++;
            end
            tick();
        end
        tests_run++;
        if (run != 5 || gaps != 0 || first != 0) begin
            tests_failed++;
            $display("FAIL b2b_stream: packets=%0d first=%0d errors=%0d required 5/0/0",
                     run, first, gaps);
        end
        tests_run++;
        if (busy1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_busy: busy=%b required 0", busy1);
        end
    endtask

    // 300 cycles of target=0 requests: exact count first, then saturation.
    task automatic test_drop_saturate();
        int acc, saw;
        logic ready_s;
        do_reset();
        tx_ready = 1'b1;
        acc = 0; saw = 0;
        req_valid  = 1'b1;
        req_target = 4'h0;
        for (int i = 0; i < 10; i++) begin
            ready_s = req_ready1;
            tick();
            if (ready_s) acc++;
        end
        req_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if (drop_cnt1 !== 8'(acc)) begin
            tests_failed++;
            $display("FAIL drop_count: drop_cnt=%0d required %0d", drop_cnt1, acc);
        end
        req_valid = 1'b1;
        for (int i = 0; i < 290; i++) begin
            tick();
            if (tx_valid1 === 1'b1) saw++;
        end
        req_valid = 1'b0;
        repeat (3) tick();
        tests_run++;
        if (drop_cnt1 !== 8'd255 || saw != 0) begin
            tests_failed++;
            $display("FAIL drop_saturate: drop_cnt=%0d valid_cycles=%0d required 255/0",
                     drop_cnt1, saw);
        end
    endtask

    // Reset while in SEND with three entries queued.
    task automatic test_reset_mid();
        int saw;
        do_reset();
        push(4'b0100, 8'h01);
        push(4'b0100, 8'h02);
        push(4'b0100, 8'h03);
        push(4'b0100, 8'h04);
        tests_run++;
        if (tx_valid1 !== 1'b1 || busy1 !== 1'b1 || req_ready1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_pre: valid=%b busy=%b ready=%b required 1/1/1",
                     tx_valid1, busy1, req_ready1);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({tx_valid1, tx_type1, tx_target1, tx_data1, busy1, req_ready1} !==
            {1'b0, T_ERR, 4'h0, 8'h00, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL rstmid_async: valid=%b type=%0d tgt=%h data=%h busy=%b ready=%b required 0/0/0/00/0/1",
                     tx_valid1, tx_type1, tx_target1, tx_data1, busy1, req_ready1);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_valid1 === 1'b1) saw++;
        end
        tests_run++;
        if (saw != 0) begin
            tests_failed++;
            $display("FAIL rstmid_post: valid_cycles=%0d required 0", saw);
        end
    endtask

`ifdef TX_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        push(4'b0100, 8'h01);
        push(4'b0100, 8'h02);
        n = 0;
        while (tx_valid1 === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        tests_run++;
        if (n != 16 || tx_timeout1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_abort: valid_cycles=%0d pulse=%b required 16/1", n, tx_timeout1);
        end
        tick();   // IDLE pops the second entry
        tests_run++;
        if ({tx_timeout1, tx_valid1, tx_data1, drop_cnt1} !== {1'b0, 1'b1, 8'h02, 8'h00}) begin
            tests_failed++;
            $display("FAIL timeout_next: pulse=%b valid=%b data=%h drop=%0d required 0/1/02/0",
                     tx_timeout1, tx_valid1, tx_data1, drop_cnt1);
        end
        repeat (15) tick();
        tx_ready = 1'b1;   // ready on the 16th stall cycle
        tick();
        tests_run++;
        if ({tx_timeout1, tx_valid1, tx_type1} !== {1'b0, 1'b0, T_ERR}) begin
            tests_failed++;
            $display("FAIL timeout_handshake_wins: pulse=%b valid=%b type=%0d required 0/0/0",
                     tx_timeout1, tx_valid1, tx_type1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_classify();
        test_back_to_back();
        test_drop_saturate();
        test_reset_mid();
`ifdef TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/port_pkt_tx.md
Name: port_pkt_tx

Overview:
Per-port packet transmitter. This is the ingress-side generator that builds the {source, target, type} packets which the switch parser classifies.
- Accepts host requests into a small FIFO.
- Classifies each request with the same legality rules the parser uses.
- Drops and counts illegal requests.
- Presents legal packets to the switch over a valid/ready interface.
- One instance per switch port; PORT_ID fixes the one-hot source.

Parameters:
PORT_ID, 0, port index 0..3; source = 4'b0001 << PORT_ID
DATA_W, 8, payload width
DEPTH, 4, request FIFO depth, power of 2, >= 2
TIMEOUT, 16, stall cycles before abort (only used with TX_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  FIFO not full
req_target  in  4  destination port mask
req_data  in  DATA_W  payload
tx_valid  out  1  packet valid toward switch
tx_ready  in  1  switch accepts packet
tx_source  out  4  one-hot source (constant)
tx_target  out  4  destination mask
tx_data  out  DATA_W  payload
tx_type  out  p_type  SDP/MDP/BDP; ERR when idle
drop_cnt  out  8  illegal-request count, saturating
tx_timeout  out  1  one-cycle abort pulse
busy  out  1  FIFO non-empty or tx_valid high

Behaviour:
- Reset values:
  - tx_valid=0, tx_target=0, tx_data=0, tx_type=ERR
  - drop_cnt=0, tx_timeout=0, busy=0, req_ready=1
  - tx_source is always 4'b0001<<PORT_ID
  - Reset mid-operation discards the FIFO and any in-flight packet.
- FIFO: push on req_valid&&req_ready. req_ready = !full (registered count).
  - A pop in the same cycle does not make req_ready high while full: no pass-through.
  - Pointers wrap modulo DEPTH; count range is 0..DEPTH.
- Classification of the popped entry (combinational on FIFO head):
  - popcount(target): 1 -> SDP; 2 or 3 -> MDP; 4 -> BDP; 0 -> illegal.
  - Legal iff target!=0 AND ((target & source)==0 OR target==4'hF).
- FSM states: IDLE, SEND.
  - IDLE, FIFO non-empty: pop head at the edge.
    - Legal: load tx_target/tx_data/tx_type, set tx_valid, go to SEND.
    - Illegal: drop_cnt+1 (saturates at 255), stay IDLE, tx outputs unchanged.
  - IDLE, FIFO empty: tx_type=ERR, tx_valid=0.
  - SEND: tx_target/tx_data/tx_type and tx_valid stay stable until tx_ready=1.
  - SEND, handshake at edge with FIFO non-empty and head legal: load the next packet and stay in SEND (back-to-back, no bubble).
  - SEND, handshake at edge with head illegal: pop it, count the drop, go to IDLE, tx_valid=0.
  - SEND, handshake at edge with FIFO empty: go to IDLE, tx_valid=0, tx_type=ERR.
- Latency: request accepted at edge E0 into an empty FIFO with FSM in IDLE -> tx_valid high after edge E1.
- Ordering: packets leave in acceptance order. Only illegal entries are removed.
- A push and a pop in the same cycle leave the count unchanged.
- tx_timeout is 0 unless TX_TIMEOUT_EN is defined.
- busy = (count!=0) || tx_valid.

Optional Feature:
TX_TIMEOUT_EN
- Defined:
  - 8-bit stall counter, cleared on entering SEND and on every handshake.
  - Increments each SEND cycle with tx_ready=0.
  - On reaching TIMEOUT, the packet is abandoned: tx_valid=0 next cycle, tx_timeout pulses 1 cycle, FSM goes to IDLE. The packet is not counted in drop_cnt.
  - If tx_ready=1 in the same cycle the count hits TIMEOUT, the handshake wins and there is no abort.
- Undefined: no counter; SEND waits indefinitely; tx_timeout tied 0.

Test Plan:
- PORT_ID=0, single req target=4'b0100 data=8'hA5, tx_ready=1 -> tx_valid one cycle after acceptance: source=0001, target=0100, type=SDP, data=A5; then idle with tx_type=ERR.
- PORT_ID=1, reqs target 0010, 0000, 1111, 0101 -> 0010 and 0000 dropped (drop_cnt=2); 1111 sent as BDP; 0101 sent as MDP; order preserved.
- tx_ready=0, push 5 reqs with DEPTH=4 -> req_ready low after the FIFO fills. The first entry is already in SEND, so 5 total are accepted before stall. Releasing tx_ready gives back-to-back tx_valid for 5 cycles.
- 256 illegal requests (target=0) -> drop_cnt saturates at 255, no tx_valid.
- rst_n low while in SEND with 3 FIFO entries -> outputs at reset values immediately; no packet emitted after release.
- TX_TIMEOUT_EN, TIMEOUT=16, tx_ready held 0 -> tx_timeout pulse after 16 stall cycles, tx_valid drops, the next FIFO entry is issued; tx_ready=1 on cycle 16 -> normal handshake, no pulse.
